// File: rtl/int_pkg.sv
// Shared types and constants for the interrupt controller.
package int_pkg;

    localparam int unsigned NUM_SRC     = 3;
    localparam int unsigned IE_GLOBAL   = 0;
    localparam int unsigned IE_SRC_LSB  = 1;
    localparam int unsigned STACK_DEPTH = 3;

    typedef enum logic {IDLE, PRESENT} state_t;

    typedef struct packed {
        logic [1:0]  level;
        logic [31:0] epc;
    } stk_entry_t;

    // Highest-numbered requesting source wins; 0 means no request.
    function automatic logic [1:0] pick_src(input logic [NUM_SRC-1:0] req);
        pick_src = 2'd0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            if (req[k-1]) pick_src = 2'(k);
        end
    endfunction

endpackage

// File: rtl/int_ctrl_if.sv
// Pipeline-side bundle of the interrupt controller; master drives requests, slave is the controller.
interface int_ctrl_if #(
    parameter int unsigned W = 32
);
    import int_pkg::*;

    logic [NUM_SRC-1:0] irq_in;
    logic               lock;
    logic [W-1:0]       PC_plus;
    logic               eret;
    logic               ie_we;
    logic [W-1:0]       ie_din;
    logic               int_trigger;
    logic [1:0]         which_int;
    logic [W-1:0]       EPC;
    logic [W-1:0]       IE;
    logic [1:0]         int_level;
    logic [W-1:0]       epc_ret;

    modport master (
        output irq_in, lock, PC_plus, eret, ie_we, ie_din,
        input  int_trigger, which_int, EPC, IE, int_level, epc_ret
    );

    modport slave (
        input  irq_in, lock, PC_plus, eret, ie_we, ie_din,
        output int_trigger, which_int, EPC, IE, int_level, epc_ret
    );

endinterface

// File: rtl/int_stack.sv
// Three-entry LIFO of service levels and return PCs; pop is applied before push.
module int_stack
    import int_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_push,
    input  logic       i_pop,
    input  stk_entry_t i_din,
    output stk_entry_t o_top,
    output logic       o_empty
);

    stk_entry_t r_mem [STACK_DEPTH];
    logic [1:0] r_cnt;
    logic       w_pop_en;
    logic [1:0] w_cnt_pop;

    always_comb begin
        w_pop_en  = i_pop && (r_cnt != 2'd0);
        w_cnt_pop = r_cnt - {1'b0, w_pop_en};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 2'd0;
            for (int i = 0; i < STACK_DEPTH; i++) r_mem[i] <= '0;
        end else if (i_push && (w_cnt_pop < 2'(STACK_DEPTH))) begin
            r_mem[w_cnt_pop] <= i_din;
            r_cnt            <= w_cnt_pop + 2'd1;
        end else begin
            r_cnt <= w_cnt_pop;
        end
    end

    always_comb begin
        o_empty = (r_cnt == 2'd0);
        o_top   = o_empty ? '0 : r_mem[r_cnt - 2'd1];
    end

endmodule

// File: rtl/int_ctrl.sv
// Edge-latched, IE-masked, strictly prioritised interrupt issue with a lock-aware handshake
// and a nested service stack unwound by eret.
module int_ctrl
    import int_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input logic       clk,
    input logic       rst,
    int_ctrl_if.slave bus
);

    state_t             r_state, w_state_d;
    logic [NUM_SRC-1:0] r_irq_q, r_pending, w_rise, w_elig, w_clr;
    logic               r_trig, w_trig_d;
    logic [1:0]         r_which, w_which_d, w_cand;
    logic [W-1:0]       r_epc, w_epc_d, r_ie;
    logic               w_push, w_pop, w_empty;
    stk_entry_t         w_top, w_din;

    always_comb begin
        w_rise = bus.irq_in & ~r_irq_q;
        for (int k = 1; k <= NUM_SRC; k++) begin
            w_elig[k-1] = r_pending[k-1] & r_ie[IE_SRC_LSB+k-1] & r_ie[IE_GLOBAL]
                          & (2'(k) > w_top.level);
        end
        w_cand = pick_src(w_elig);
    end

    always_comb begin
        w_state_d = r_state;
        w_trig_d  = r_trig;
        w_which_d = r_which;
        w_epc_d   = r_epc;
        w_clr     = '0;
        w_push    = 1'b0;
        w_pop     = bus.eret;
        unique case (r_state)
            IDLE: begin
                if ((w_cand != 2'd0) && !bus.eret) begin
                    w_state_d = PRESENT;
                    w_trig_d  = 1'b1;
                    w_which_d = w_cand;
                    w_epc_d   = bus.PC_plus;
                    w_clr     = NUM_SRC'(1) << (w_cand - 2'd1);
                end
            end
            PRESENT: begin
                // Held until the pipeline register is free to capture it.
                if (!bus.lock) begin
                    w_push    = 1'b1;
                    w_state_d = IDLE;
                    w_trig_d  = 1'b0;
                    w_which_d = 2'd0;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_irq_q   <= '0;
            r_pending <= '0;
            r_trig    <= 1'b0;
            r_which   <= 2'd0;
            r_epc     <= '0;
            r_ie      <= '0;
        end else begin
            r_state   <= w_state_d;
            r_irq_q   <= bus.irq_in;
            r_pending <= (r_pending & ~w_clr) | w_rise;
            r_trig    <= w_trig_d;
            r_which   <= w_which_d;
            r_epc     <= w_epc_d;
            if (bus.ie_we) r_ie <= bus.ie_din;
        end
    end

    assign w_din = '{level: r_which, epc: r_epc};

    int_stack u_stack (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_din),
        .o_top   (w_top),
        .o_empty (w_empty)
    );

    always_comb begin
        bus.int_trigger = r_trig;
        bus.which_int   = r_which;
        bus.EPC         = r_epc;
        bus.IE          = r_ie;
        bus.int_level   = w_empty ? 2'd0 : w_top.level;
        bus.epc_ret     = w_top.epc;
    end

endmodule

// File: doc/int_ctrl.md
# int_ctrl

Interrupt controller feeding the fetch/decode pipeline register: latches edge-triggered requests from three sources and applies the IE mask and strict priority. Each issued interrupt is presented with its return PC and a source code. A lock-aware handshake holds the interrupt until the pipeline register actually captures it. Nested service levels and their return PCs are kept on a 3-entry stack, and the stack is unwound on `eret`.

## Interface
Parameters:
- `NUM_SRC`, 3, number of interrupt sources; fixed by the 2-bit source code (code 0 = none).
- `W`, 32, PC/EPC/IE width.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `irq_in`  in  3  raw requests; bit k-1 is source k; rising edge = request.
- `lock`  in  1  pipeline stall; a presented interrupt is accepted only in a cycle with `lock`=0.
- `PC_plus`  in  32  current fetch PC+4; becomes EPC at issue.
- `eret`  in  1  one-cycle pulse: return from the current interrupt level.
- `ie_we`  in  1  IE register write enable.
- `ie_din`  in  32  IE write data.
- `int_trigger`  out  1  interrupt presented to the pipeline register.
- `which_int`  out  2  source code of the presented interrupt (1..3), 0 when idle.
- `EPC`  out  32  return PC of the presented interrupt.
- `IE`  out  32  IE register. Bit 0 is the global enable; bits 3:1 are the per-source enables; bits 31:4 are stored, no effect.
- `int_level`  out  2  level currently in service (top of stack), 0 = none.
- `epc_ret`  out  32  EPC at top of stack (eret target), 0 when stack empty.

## Operation
- Edge detect:
  - `irq_q` registers `irq_in`.
  - `pending[k]` is set when `irq_in[k] & ~irq_q[k]`.
  - `pending[k]` is cleared when source k is issued.
  - A set and a clear in the same cycle leave `pending[k]`=1.
- Candidate: the highest k with `pending[k] & IE[k] & IE[0]` and `k > int_level`. Source 3 is the highest priority.
- FSM:
  - IDLE:
    - If a candidate exists and `eret`=0, go to PRESENT.
    - On that transition: register `int_trigger`=1, `which_int`=k, `EPC`=`PC_plus`, and clear `pending[k]`.
  - PRESENT:
    - Outputs are held stable while `lock`=1.
    - The first cycle with `lock`=0 is acceptance.
    - At acceptance: push {k, EPC}, then return to IDLE with `int_trigger`=0, `which_int`=0. `EPC` holds its value.
    - No new issue is made in the acceptance cycle.
- `eret`:
  - Pops the stack when it is non-empty.
  - Ignored when the stack is empty.
  - Issue from IDLE is suppressed in a cycle with `eret`=1.
- `eret` in the same cycle as acceptance: pop first, then push. Net effect: the top entry is replaced.
- Stack cannot overflow: each push has a strictly higher level than the current top, so the depth is at most 3.
- IE:
  - `ie_we` loads `ie_din` at the edge.
  - The write takes effect on candidate selection from the next cycle.
  - Clearing an enable does not withdraw an interrupt already in PRESENT.
- Masked requests remain pending until enabled or until reset.

## Timing
- Reset values (asynchronous):
  - Outputs: `int_trigger`=0, `which_int`=0, `EPC`=0, `IE`=0, `int_level`=0, `epc_ret`=0.
  - Internal: `irq_q`=0, `pending`=0, stack empty, FSM in IDLE.
- Latency:
  - `irq_in` first sampled high at edge E sets `pending` at E.
  - `int_trigger` rises at E+1.
  - Acceptance happens at the first edge ≥E+2 ending a cycle with `lock`=0.
- `int_trigger` high time: exactly 1 cycle when `lock`=0, otherwise 1 + number of locked cycles.
- `int_level`/`epc_ret` update at the edge ending the acceptance or `eret` cycle.
- Back-to-back issue: minimum 1 idle cycle between two `int_trigger` pulses.
- Reset mid-PRESENT or mid-service: everything clears immediately; no interrupt is delivered.

## Structure
- Package `int_pkg`:
  - `NUM_SRC`, `IE_GLOBAL`=0, `IE_SRC_LSB`=1.
  - FSM enum {IDLE, PRESENT}.
  - Stack entry struct {level[1:0], epc[31:0]}.
- Sub-module `int_stack`: 3-entry LIFO with push, pop, simultaneous pop+push, top outputs, and an empty flag. Reset empties it.

## Test plan
- IE=0xF, lock=0, pulse `irq_in`=3'b001:
  - `int_trigger` is 1 for exactly 1 cycle, with `which_int`=1 and `EPC`=`PC_plus` at issue.
  - Then `int_level`=1.
- IE=0xF, irq 1 and 3 rise in the same cycle:
  - Source 3 is issued first.
  - Source 1 stays pending until `eret` and is then issued.
- In service at level 2 with EPC=0x100, raise source 3:
  - Source 3 is accepted; `int_level`=3.
  - `eret` → `int_level`=2, `epc_ret`=0x100.
  - Raise source 1 at level 2: no issue until two `eret`s.
- `lock`=1 for 4 cycles while in PRESENT:
  - `int_trigger`, `which_int` and `EPC` are stable for 5 cycles.
  - Exactly one push occurs.
- IE=0x1 (sources masked), pulse irq 2:
  - No trigger.
  - Write IE=0x5 → source 2 is issued.
- `rst` asserted while in PRESENT with stack depth 2:
  - All outputs read 0 in the same cycle.
  - After reset releases, no trigger appears without a new edge.
